// File: rtl/prim_alert_receiver.sv
// rtl/prim_alert_receiver.sv - receiving end of the differential alert protocol
//
// Decodes {alert_p, alert_n} from one alert sender, completes the four-phase
// handshake on {ack_p, ack_n}, issues in-band pings on {ping_p, ping_n} and
// reports alert / ping answer / signal-integrity failure as registered pulses.
//
// Ports:
//   clk_i         clock
//   rst_ni        asynchronous active-low reset
//   ping_req_i    ping request, honoured only when no ping is pending
//   init_trig_i   force both rx pairs equal to request an in-band reset
//   alert_tx_i    {alert_p, alert_n} from the sender
//   alert_rx_o    {ping_p, ping_n, ack_p, ack_n} to the sender
//   alert_o       one-cycle pulse: alert received
//   ping_ok_o     one-cycle pulse: pending ping answered
//   integ_fail_o  high each cycle a signal-integrity error is seen
module prim_alert_receiver #(
  parameter bit AsyncOn = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ping_req_i,
  input  logic       init_trig_i,
  input  logic [1:0] alert_tx_i,
  output logic [3:0] alert_rx_o,
  output logic       alert_o,
  output logic       ping_ok_o,
  output logic       integ_fail_o
);

  typedef enum logic [1:0] {
    Idle      = 2'b00,
    HsAckWait = 2'b01,
    Pause0    = 2'b10,
    Pause1    = 2'b11
  } state_e;

  logic   alert_p, alert_n;
  logic   eq, sigint, level;
  logic   eq_d, eq_q, level_d, level_q;
  state_e state_d, state_q;
  logic   ack_d, ack_n_d, ack_q, ack_n_q;
  logic   ping_p_d, ping_n_d, ping_p_q, ping_n_q;
  logic   ping_pend_d, ping_pend_q;
  logic   alert_d, alert_q, ping_ok_d, ping_ok_q, integ_fail_d, integ_fail_q;

  // Optional two-flop synchronizer; idle value of the pair is p=0 / n=1.
  if (AsyncOn) begin : g_sync
    logic [1:0] sync1_d, sync1_q, sync2_d, sync2_q;
    always_comb begin
      sync1_d = alert_tx_i;
      sync2_d = sync1_q;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        sync1_q <= 2'b01;
        sync2_q <= 2'b01;
      end else begin
        sync1_q <= sync1_d;
        sync2_q <= sync2_d;
      end
    end
    assign alert_p = sync2_q[1];
    assign alert_n = sync2_q[0];
  end else begin : g_nosync
    assign alert_p = alert_tx_i[1];
    assign alert_n = alert_tx_i[0];
  end

  // Decode. Across a clock boundary the two wires may land one cycle apart,
  // so a lone equal cycle is treated as skew: the level is held and only a
  // second consecutive equal cycle counts as an integrity failure.
  always_comb begin
    eq = (alert_p == alert_n);
    if (AsyncOn) begin
      sigint = eq & eq_q;
      level  = eq ? level_q : alert_p;
    end else begin
      sigint = eq;
      level  = alert_p;
    end
    eq_d    = eq;
    level_d = level;
  end

  // Next-state logic; integrity failures and init requests park the FSM.
  always_comb begin
    state_d = state_q;
    if (init_trig_i || sigint) begin
      state_d = Idle;
    end else begin
      case (state_q)
        Idle:      if (level)  state_d = HsAckWait;
        HsAckWait: if (!level) state_d = Pause0;
        Pause0:    state_d = Pause1;
        Pause1:    state_d = Idle;
        default:   state_d = Idle;
      endcase
    end
  end

  // Output and ping bookkeeping.
  always_comb begin
    ack_d        = 1'b0;
    alert_d      = 1'b0;
    ping_ok_d    = 1'b0;
    integ_fail_d = 1'b0;
    ping_p_d     = ping_p_q;
    ping_pend_d  = ping_pend_q;

    if (ping_req_i && !ping_pend_q) begin
      ping_p_d    = ~ping_p_q;
      ping_pend_d = 1'b1;
    end

    if (init_trig_i) begin
      ping_p_d    = 1'b0;
      ping_pend_d = 1'b0;
    end else if (sigint) begin
      // Pending ping survives so it can still be answered after recovery.
      integ_fail_d = 1'b1;
    end else begin
      case (state_q)
        Idle: begin
          if (level) begin
            ack_d = 1'b1;
            if (ping_pend_q) begin
              ping_ok_d   = 1'b1;
              ping_pend_d = 1'b0;
            end else begin
              alert_d = 1'b1;
            end
          end
        end
        HsAckWait: ack_d = level;
        default:   ack_d = 1'b0;
      endcase
    end

    // During init both pairs are driven equal (0/0) so the sender sees sigint.
    ping_n_d = init_trig_i ? 1'b0 : ~ping_p_d;
    ack_n_d  = init_trig_i ? 1'b0 : ~ack_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= Idle;
      eq_q         <= 1'b0;
      level_q      <= 1'b0;
      ack_q        <= 1'b0;
      ack_n_q      <= 1'b1;
      ping_p_q     <= 1'b0;
      ping_n_q     <= 1'b1;
      ping_pend_q  <= 1'b0;
      alert_q      <= 1'b0;
      ping_ok_q    <= 1'b0;
      integ_fail_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      eq_q         <= eq_d;
      level_q      <= level_d;
      ack_q        <= ack_d;
      ack_n_q      <= ack_n_d;
      ping_p_q     <= ping_p_d;
      ping_n_q     <= ping_n_d;
      ping_pend_q  <= ping_pend_d;
      alert_q      <= alert_d;
      ping_ok_q    <= ping_ok_d;
      integ_fail_q <= integ_fail_d;
    end
  end

  assign alert_rx_o   = {ping_p_q, ping_n_q, ack_q, ack_n_q};
  assign alert_o      = alert_q;
  assign ping_ok_o    = ping_ok_q;
  assign integ_fail_o = integ_fail_q;

endmodule

// File: tb/tb_prim_alert_receiver.sv
// tb/tb_prim_alert_receiver.sv - self-checking bench for prim_alert_receiver
module tb_prim_alert_receiver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pr, it, pr1, it1;
  logic [1:0] tx, tx1;
  logic [3:0] rx, rx1;
  logic       a, pok, fl, a1, pok1, fl1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  prim_alert_receiver #(.AsyncOn(1'b0)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .ping_req_i(pr), .init_trig_i(it),
    .alert_tx_i(tx), .alert_rx_o(rx), .alert_o(a), .ping_ok_o(pok),
    .integ_fail_o(fl)
  );

  prim_alert_receiver #(.AsyncOn(1'b1)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .ping_req_i(pr1), .init_trig_i(it1),
    .alert_tx_i(tx1), .alert_rx_o(rx1), .alert_o(a1), .ping_ok_o(pok1),
    .integ_fail_o(fl1)
  );

  typedef struct {
    int         id;
    logic       pr;
    logic       it;
    logic [1:0] tx;
    logic [3:0] rx;
    logic       a;
    logic       pok;
    logic       fl;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  task automatic add(input logic p, input logic i, input logic [1:0] t,
                     input logic [3:0] r, input logic ea, input logic ep,
                     input logic ef);
    vec_t v;
    v.id = vecs.size();
    v.pr = p; v.it = i; v.tx = t; v.rx = r; v.a = ea; v.pok = ep; v.fl = ef;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic pop_cmp();
    vec_t e;
    e = sb.pop_front();
    chk($sformatf("v%0d rx", e.id), rx, e.rx);
    chk($sformatf("v%0d alert_o", e.id), {3'b0, a}, {3'b0, e.a});
    chk($sformatf("v%0d ping_ok_o", e.id), {3'b0, pok}, {3'b0, e.pok});
    chk($sformatf("v%0d integ_fail_o", e.id), {3'b0, fl}, {3'b0, e.fl});
  endtask

  initial begin
    // {ping_req, init_trig, {alert_p,alert_n}} -> {rx, alert, ping_ok, integ}
    // clean alert, early level ignored in Pause, re-accept 3 cycles after release
    add(0,0,2'b01,4'b0101,0,0,0);
    add(0,0,2'b10,4'b0110,1,0,0);
    add(0,0,2'b10,4'b0110,0,0,0);
    add(0,0,2'b10,4'b0110,0,0,0);
    add(0,0,2'b01,4'b0101,0,0,0);
    add(0,0,2'b10,4'b0101,0,0,0);
    add(0,0,2'b10,4'b0101,0,0,0);
    add(0,0,2'b10,4'b0110,1,0,0);
    for (int i = 0; i < 3; i++) add(0,0,2'b01,4'b0101,0,0,0);
    // ping round trip, second request ignored
    add(1,0,2'b01,4'b1001,0,0,0);
    add(1,0,2'b01,4'b1001,0,0,0);
    add(0,0,2'b10,4'b1010,0,1,0);
    add(0,0,2'b10,4'b1010,0,0,0);
    for (int i = 0; i < 3; i++) add(0,0,2'b01,4'b1001,0,0,0);
    add(1,0,2'b01,4'b0101,0,0,0);
    add(0,0,2'b10,4'b0110,0,1,0);
    // sigint mid handshake, then a normal alert
    add(0,0,2'b10,4'b0110,0,0,0);
    add(0,0,2'b11,4'b0101,0,0,1);
    add(0,0,2'b11,4'b0101,0,0,1);
    add(0,0,2'b00,4'b0101,0,0,1);
    add(0,0,2'b01,4'b0101,0,0,0);
    add(0,0,2'b10,4'b0110,1,0,0);
    add(0,0,2'b01,4'b0101,0,0,0);
    // sigint with a ping pending keeps the ping
    add(1,0,2'b01,4'b1001,0,0,0);
    add(0,0,2'b01,4'b1001,0,0,0);
    add(0,0,2'b11,4'b1001,0,0,1);
    add(0,0,2'b10,4'b1010,0,1,0);
    for (int i = 0; i < 3; i++) add(0,0,2'b01,4'b1001,0,0,0);
    // ping request together with an Idle alert
    add(1,0,2'b10,4'b0110,1,0,0);
    for (int i = 0; i < 3; i++) add(0,0,2'b01,4'b0101,0,0,0);
    add(0,0,2'b10,4'b0110,0,1,0);
    for (int i = 0; i < 3; i++) add(0,0,2'b01,4'b0101,0,0,0);
    // ping request during a handshake
    add(0,0,2'b10,4'b0110,1,0,0);
    add(1,0,2'b10,4'b1010,0,0,0);
    for (int i = 0; i < 3; i++) add(0,0,2'b01,4'b1001,0,0,0);
    add(0,0,2'b10,4'b1010,0,1,0);
    for (int i = 0; i < 3; i++) add(0,0,2'b01,4'b1001,0,0,0);
    // init trigger with a ping pending
    add(1,0,2'b01,4'b0101,0,0,0);
    add(0,1,2'b01,4'b0000,0,0,0);
    add(0,1,2'b10,4'b0000,0,0,0);
    add(0,1,2'b11,4'b0000,0,0,0);
    add(0,0,2'b01,4'b0101,0,0,0);
    add(0,0,2'b10,4'b0110,1,0,0);
    for (int i = 0; i < 3; i++) add(0,0,2'b01,4'b0101,0,0,0);

    rst_n = 1'b0;
    pr = 1'b0; it = 1'b0; tx = 2'b01;
    pr1 = 1'b0; it1 = 1'b0; tx1 = 2'b01;
    #12;
    chk("reset rx", rx, 4'b0101);
    chk("reset outs", {1'b0, a, pok, fl}, 4'b0000);
    chk("reset rx async", rx1, 4'b0101);
    chk("reset outs async", {1'b0, a1, pok1, fl1}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Table on the synchronous instance through the scoreboard.
    foreach (vecs[i]) begin
      @(negedge clk);
      if (sb.size() > 0) pop_cmp();
      pr = vecs[i].pr;
      it = vecs[i].it;
      tx = vecs[i].tx;
      sb.push_back(vecs[i]);
    end
    @(negedge clk);
    pop_cmp();
    pr = 1'b0; it = 1'b0; tx = 2'b01;

    // Asynchronous instance: skew on entry, release, then a 3-cycle sigint.
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 0)                 tx1 = 2'b11;
      else if (k <= 4)            tx1 = 2'b10;
      else if (k >= 10 && k <= 12) tx1 = 2'b11;
      else                        tx1 = 2'b01;
      @(posedge clk);
      #1;
      chk($sformatf("async k%0d alert_o", k), {3'b0, a1}, {3'b0, k == 3});
      chk($sformatf("async k%0d integ_fail_o", k), {3'b0, fl1}, {3'b0, (k == 13 || k == 14)});
      chk($sformatf("async k%0d ack_p", k), {3'b0, rx1[1]}, {3'b0, (k >= 3 && k <= 6)});
      chk($sformatf("async k%0d ping_ok_o", k), {3'b0, pok1}, 4'b0000);
    end

    // Asynchronous reset mid-handshake with a ping pending.
    @(negedge clk);
    pr = 1'b1;
    tx = 2'b10;
    @(posedge clk);
    #1;
    pr = 1'b0;
    chk("pre-reset rx", rx, 4'b1010);
    chk("pre-reset alert_o", {3'b0, a}, 4'b0001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset rx", rx, 4'b0101);
    chk("async reset outs", {1'b0, a, pok, fl}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post-reset rx", rx, 4'b0110);
    chk("post-reset alert_o (ping lost)", {1'b0, a, pok, fl}, 4'b0100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
